// File: rtl/rst_seq_pkg.sv
// rtl/rst_seq_pkg.sv - shared state encoding and default parameters for the reset sequencer
package rst_seq_pkg;

  localparam int ST_W = 2;

  typedef enum logic [ST_W-1:0] {
    ST_ASSERT  = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } seq_state_e;

  localparam int DEF_NUM_CH    = 4;
  localparam int DEF_CNT_W     = 16;
  localparam int DEF_HOLD_CYC  = 5000;
  localparam int DEF_STAGE_CYC = 8;
  localparam int DEF_WDOG_CYC  = 1024;

endpackage

// File: rtl/rst_seq_wdog.sv
// rtl/rst_seq_wdog.sv - readiness watchdog: counts not-ready cycles in RUN and requests a restart
module rst_seq_wdog #(
  parameter int CNT_W    = 16,
  parameter int WDOG_CYC = 1024,
  parameter int NUM_CH   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic [NUM_CH-1:0] ch_rdy,
  output logic              restart
);

  localparam logic [CNT_W-1:0] WCNT_LAST = CNT_W'(WDOG_CYC - 1);

  logic [CNT_W-1:0] wcnt_q;
  logic             all_rdy;

  assign all_rdy = &ch_rdy;
  assign restart = run && !all_rdy && (wcnt_q == WCNT_LAST);

  // Count consecutive not-ready cycles while running; any ready cycle, leaving RUN or firing clears it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt_q <= '0;
    end else if (!run || all_rdy || restart) begin
      wcnt_q <= '0;
    end else begin
      wcnt_q <= wcnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/rst_seq_gen.sv
// rtl/rst_seq_gen.sv - multi-channel reset sequencer; watchdog enabled by RST_SEQ_WDOG_EN
module rst_seq_gen
  import rst_seq_pkg::*;
#(
  parameter int NUM_CH    = DEF_NUM_CH,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int HOLD_CYC  = DEF_HOLD_CYC,
  parameter int STAGE_CYC = DEF_STAGE_CYC,
  parameter int WDOG_CYC  = DEF_WDOG_CYC
) (
  input  logic              pbus_clk,
  input  logic              rst_sys_n,
  input  logic              sw_rst_req_i,
  input  logic [NUM_CH-1:0] ch_rdy_i,
  output logic [NUM_CH-1:0] rst_ch_n_o,
  output logic              seq_done_o,
  output logic              sw_rst_ack_o,
  output logic              wdog_trip_o
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_CYC - 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_CH - 1);
  localparam logic [IDX_W-1:0] FIRST_IDX  = IDX_W'(1);

  seq_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [NUM_CH-1:0] ch_q, ch_d;
  logic              done_q, done_d;
  logic              ack_q, ack_d;
  logic              req_q;
  logic              wdog_restart;

`ifdef RST_SEQ_WDOG_EN
  logic trip_q;

  rst_seq_wdog #(
    .CNT_W    (CNT_W),
    .WDOG_CYC (WDOG_CYC),
    .NUM_CH   (NUM_CH)
  ) u_wdog (
    .clk     (pbus_clk),
    .rst_n   (rst_sys_n),
    .run     (state_q == ST_RUN),
    .ch_rdy  (ch_rdy_i),
    .restart (wdog_restart)
  );

  // Sticky trip flag: set by a watchdog restart, cleared only by a software request or system reset
  always_ff @(posedge pbus_clk or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      trip_q <= 1'b0;
    end else if (sw_rst_req_i) begin
      trip_q <= 1'b0;
    end else if (wdog_restart) begin
      trip_q <= 1'b1;
    end
  end

  assign wdog_trip_o = trip_q;
`else
  logic unused_ch_rdy;

  assign unused_ch_rdy = ^ch_rdy_i;
  assign wdog_restart  = 1'b0;
  assign wdog_trip_o   = 1'b0;
`endif

  // Sequencer state and registered outputs
  always_ff @(posedge pbus_clk or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      state_q <= ST_ASSERT;
      cnt_q   <= '0;
      idx_q   <= FIRST_IDX;
      ch_q    <= '0;
      done_q  <= 1'b0;
      ack_q   <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      ch_q    <= ch_d;
      done_q  <= done_d;
      ack_q   <= ack_d;
      req_q   <= sw_rst_req_i;
    end
  end

  // Next state: software request beats watchdog restart, which beats normal hold/release progression
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    ch_d    = ch_q;
    done_d  = done_q;
    ack_d   = sw_rst_req_i & ~req_q;

    if (sw_rst_req_i || wdog_restart) begin
      state_d = ST_ASSERT;
      cnt_d   = '0;
      idx_d   = FIRST_IDX;
      ch_d    = '0;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        ST_ASSERT: begin
          if (cnt_q == HOLD_LAST) begin
            ch_d[0] = 1'b1;
            cnt_d   = '0;
            if (NUM_CH == 1) begin
              done_d  = 1'b1;
              state_d = ST_RUN;
            end else begin
              state_d = ST_RELEASE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_RELEASE: begin
          if (cnt_q == STAGE_LAST) begin
            ch_d[idx_q] = 1'b1;
            cnt_d       = '0;
            idx_d       = idx_q + 1'b1;
            if (idx_q == LAST_IDX) begin
              done_d  = 1'b1;
              state_d = ST_RUN;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
  end

  assign rst_ch_n_o   = ch_q;
  assign seq_done_o   = done_q;
  assign sw_rst_ack_o = ack_q;

endmodule

// File: tb/tb_rst_seq_gen.sv
// tb/tb_rst_seq_gen.sv - randomized model-checked bench for rst_seq_gen (4-channel and 1-channel instances)
module tb_rst_seq_gen;

  localparam int N0 = 4;
  localparam int H0 = 10;
  localparam int S0 = 3;
  localparam int N1 = 1;
  localparam int H1 = 1;
  localparam int S1 = 3;
  localparam int WDC = 5;
`ifdef RST_SEQ_WDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic       pbus_clk = 1'b0;
  logic       rst_sys_n = 1'b0;
  logic       sw_rst_req = 1'b0;
  logic [3:0] ch_rdy = 4'hF;

  logic [3:0] ch0;
  logic       done0, ack0, trip0;
  logic [0:0] ch1;
  logic       done1, ack1, trip1;

  int tests = 0;
  int fails = 0;

  always #5 pbus_clk = ~pbus_clk;

  rst_seq_gen #(.NUM_CH(N0), .CNT_W(16), .HOLD_CYC(H0), .STAGE_CYC(S0), .WDOG_CYC(WDC)) u_dut (
    .pbus_clk     (pbus_clk),
    .rst_sys_n    (rst_sys_n),
    .sw_rst_req_i (sw_rst_req),
    .ch_rdy_i     (ch_rdy),
    .rst_ch_n_o   (ch0),
    .seq_done_o   (done0),
    .sw_rst_ack_o (ack0),
    .wdog_trip_o  (trip0)
  );

  rst_seq_gen #(.NUM_CH(N1), .CNT_W(16), .HOLD_CYC(H1), .STAGE_CYC(S1), .WDOG_CYC(WDC)) u_dut1 (
    .pbus_clk     (pbus_clk),
    .rst_sys_n    (rst_sys_n),
    .sw_rst_req_i (sw_rst_req),
    .ch_rdy_i     (ch_rdy[0:0]),
    .rst_ch_n_o   (ch1),
    .seq_done_o   (done1),
    .sw_rst_ack_o (ack1),
    .wdog_trip_o  (trip1)
  );

  // Reference model: per instance, edges since the current sequence started plus watchdog bookkeeping
  int seq_t[2] = '{0, 0};
  int nr[2]    = '{0, 0};
  bit mtrip[2] = '{1'b0, 1'b0};
  bit mack[2]  = '{1'b0, 1'b0};
  bit req_prev = 1'b0;

  function automatic int p_n(int d);
    return (d == 0) ? N0 : N1;
  endfunction

  function automatic int p_h(int d);
    return (d == 0) ? H0 : H1;
  endfunction

  function automatic int p_s(int d);
    return (d == 0) ? S0 : S1;
  endfunction

  function automatic bit exp_done(int d);
    return seq_t[d] >= p_h(d) + (p_n(d) - 1) * p_s(d);
  endfunction

  function automatic logic [31:0] exp_ch(int d);
    logic [31:0] v;
    v = '0;
    for (int k = 0; k < p_n(d); k++) begin
      if (seq_t[d] >= p_h(d) + k * p_s(d)) v[k] = 1'b1;
    end
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge pbus_clk or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      for (int d = 0; d < 2; d++) begin
        seq_t[d] = 0;
        nr[d]    = 0;
        mtrip[d] = 1'b0;
        mack[d]  = 1'b0;
      end
      req_prev = 1'b0;
    end else begin
      for (int d = 0; d < 2; d++) begin
        bit rdy;
        bit run;
        rdy = (d == 0) ? (&ch_rdy) : ch_rdy[0];
        run = exp_done(d);
        mack[d] = sw_rst_req && !req_prev;
        if (sw_rst_req) begin
          seq_t[d] = 0;
          nr[d]    = 0;
          mtrip[d] = 1'b0;
        end else if (WD && run && !rdy && nr[d] == WDC - 1) begin
          seq_t[d] = 0;
          nr[d]    = 0;
          mtrip[d] = 1'b1;
        end else begin
          nr[d] = (run && !rdy) ? nr[d] + 1 : 0;
          if (seq_t[d] < 1000000) seq_t[d] = seq_t[d] + 1;
        end
      end
      req_prev = sw_rst_req;
    end
  end

  // Every-cycle comparison of both instances against the model
  always @(negedge pbus_clk) begin
    chk("ch0", {28'd0, ch0}, exp_ch(0));
    chk("done0", {31'd0, done0}, {31'd0, exp_done(0)});
    chk("ack0", {31'd0, ack0}, {31'd0, mack[0]});
    chk("trip0", {31'd0, trip0}, {31'd0, mtrip[0]});
    chk("ch1", {31'd0, ch1}, exp_ch(1));
    chk("done1", {31'd0, done1}, {31'd0, exp_done(1)});
    chk("ack1", {31'd0, ack1}, {31'd0, mack[1]});
    chk("trip1", {31'd0, trip1}, {31'd0, mtrip[1]});
  end

  task automatic step();
    @(posedge pbus_clk);
    @(negedge pbus_clk);
  endtask

  int req_len = 0;
  int rdy_len = 0;

  initial begin
    repeat (3) @(negedge pbus_clk);
    chk("rst_ch", {28'd0, ch0}, 32'h0);
    chk("rst_done", {31'd0, done0}, 32'h0);
    rst_sys_n = 1'b1;

    step();
    chk("n1_ch_e1", {31'd0, ch1}, 32'h1);
    chk("n1_done_e1", {31'd0, done1}, 32'h1);
    repeat (8) step();
    chk("ch_e9", {28'd0, ch0}, 32'h0);
    step();
    chk("ch_e10", {28'd0, ch0}, 32'h1);
    repeat (3) step();
    chk("ch_e13", {28'd0, ch0}, 32'h3);
    repeat (3) step();
    chk("ch_e16", {28'd0, ch0}, 32'h7);
    repeat (2) step();
    chk("done_e18", {31'd0, done0}, 32'h0);
    step();
    chk("ch_e19", {28'd0, ch0}, 32'hF);
    chk("done_e19", {31'd0, done0}, 32'h1);

    sw_rst_req = 1'b1;
    step();
    chk("sw_clr_ch", {28'd0, ch0}, 32'h0);
    chk("sw_ack", {31'd0, ack0}, 32'h1);
    sw_rst_req = 1'b0;
    repeat (13) step();
    chk("sw_ch_e13", {28'd0, ch0}, 32'h3);
    sw_rst_req = 1'b1;
    step();
    chk("sw_e14_ch", {28'd0, ch0}, 32'h0);
    chk("sw_e14_done", {31'd0, done0}, 32'h0);
    chk("sw_e14_ack", {31'd0, ack0}, 32'h1);
    step();
    chk("sw_ack_once", {31'd0, ack0}, 32'h0);
    sw_rst_req = 1'b0;
    repeat (10) step();
    chk("resq_e10", {28'd0, ch0}, 32'h1);
    repeat (9) step();
    chk("resq_e19", {28'd0, ch0}, 32'hF);
    chk("resq_done", {31'd0, done0}, 32'h1);

    ch_rdy = 4'b1011;
    repeat (4) step();
    ch_rdy = 4'hF;
    step();
    chk("wd4_trip", {31'd0, trip0}, 32'h0);
    chk("wd4_done", {31'd0, done0}, 32'h1);
    repeat (3) step();
    ch_rdy = 4'b1011;
    repeat (5) step();
    chk("wd5_trip", {31'd0, trip0}, {31'd0, WD});
    chk("wd5_done", {31'd0, done0}, {31'd0, !WD});
    ch_rdy = 4'hF;
    repeat (19) step();
    chk("wd_rerun_done", {31'd0, done0}, 32'h1);
    chk("wd_sticky", {31'd0, trip0}, {31'd0, WD});

`ifndef RST_SEQ_WDOG_EN
    ch_rdy = 4'h0;
    repeat (100) step();
    chk("nowd_done", {31'd0, done0}, 32'h1);
    chk("nowd_trip", {31'd0, trip0}, 32'h0);
    ch_rdy = 4'hF;
`endif

    #2 rst_sys_n = 1'b0;
    #1;
    chk("async_ch", {28'd0, ch0}, 32'h0);
    chk("async_done", {31'd0, done0}, 32'h0);
    chk("async_trip", {31'd0, trip0}, 32'h0);
    chk("async_ch1", {31'd0, ch1}, 32'h0);
    @(negedge pbus_clk);
    rst_sys_n = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      if (req_len > 0) begin
        sw_rst_req = 1'b1;
        req_len--;
      end else begin
        sw_rst_req = 1'b0;
        if ($urandom_range(0, 59) == 0) req_len = $urandom_range(1, 3);
      end
      if (rdy_len > 0) begin
        rdy_len--;
      end else begin
        ch_rdy = 4'hF;
        if ($urandom_range(0, 14) == 0) begin
          ch_rdy = ~(4'b0001 << $urandom_range(0, 3));
          rdy_len = $urandom_range(1, 7);
        end
      end
      if ($urandom_range(0, 699) == 0) begin
        #2 rst_sys_n = 1'b0;
        #2 rst_sys_n = 1'b1;
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
